dmem_responder: RTL and testbench

- Data-memory responder for the Memory stage's load/store request interface; it is the far end of the address, storeData, byteEnable and storeValid signals the Memory stage drives.
- Holds a word-organised RAM and answers each request after a programmable latency.
- Drives a one-cycle loadDataValid or storeComplete pulse so that the Memory stage's stall logic gets exercised under realistic wait states.
- Drop-in alternative to the zero-wait data memory, used for latency-sensitivity testing of the pipeline.

---
 rtl/dmem_responder_pkg.sv | 18 +
 rtl/dmem_ram_array.sv | 27 ++
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state and the latched request.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_WAIT  = 2'd1,
    STORE_WAIT = 2'd2,
    COOLDOWN   = 2'd3
  } dmemState_;

  typedef struct packed {
    logic [29:0] index;
    logic [31:0] data;
    logic [3:0]  byteEnable;
    logic        isStore;
  } dmemRequest_;

endpackage

// File: rtl/dmem_ram_array.sv
// Word-organised RAM with per-byte write enables and a combinational read port.
module dmem_ram_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_index,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] rd_index,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_be[b]) begin
        mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem[rd_index];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, answers after a
// programmable latency, then spends one cooldown cycle so a held request is not re-serviced.
//
// state      | meaning
// IDLE       | waiting for a request; store has priority over load
// LOAD_WAIT  | counting down load latency, read on terminal count
// STORE_WAIT | counting down store latency, write on terminal count
// COOLDOWN   | response pulse cycle; requests ignored
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS   = 1024,
  parameter int LOAD_LATENCY  = 2,
  parameter int STORE_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  input  logic [3:0]  byteEnable,
  input  logic        storeValid,
  input  logic        loadValid,
  output logic [31:0] loadData,
  output logic        loadDataValid,
  output logic        storeComplete,
  output logic        accessFault
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);
  localparam logic [3:0]  LOAD_TC   = 4'(LOAD_LATENCY - 1);
  localparam logic [3:0]  STORE_TC  = 4'(STORE_LATENCY - 1);

  if (LOAD_LATENCY < 1 || LOAD_LATENCY > 15) begin : g_bad_load_latency
    $error("LOAD_LATENCY must be 1..15");
  end
  if (STORE_LATENCY < 1 || STORE_LATENCY > 15) begin : g_bad_store_latency
    $error("STORE_LATENCY must be 1..15");
  end

  dmemState_   state;
  dmemRequest_ req;
  logic [3:0]  count;
  logic        fault;
  logic        wr_en;
  logic [31:0] rd_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];

  // Fault is judged on the full 30-bit index so out-of-range requests never alias into the array.
  assign fault = (req.index >= DEPTH_IDX);
  assign wr_en = (state == STORE_WAIT) && (count == 4'd0) && !fault;

  dmem_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clock    (clock),
    .wr_en    (wr_en),
    .wr_index (req.index[AW-1:0]),
    .wr_data  (req.data),
    .wr_be    (req.byteEnable),
    .rd_index (req.index[AW-1:0]),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= 4'd0;
      req           <= '0;
      loadData      <= 32'd0;
      loadDataValid <= 1'b0;
      storeComplete <= 1'b0;
      accessFault   <= 1'b0;
    end else begin
      loadDataValid <= 1'b0;
      storeComplete <= 1'b0;
      accessFault   <= 1'b0;
      case (state)
        IDLE: begin
          if (storeValid) begin
            req.index      <= address[31:2];
            req.data       <= storeData;
            req.byteEnable <= byteEnable;
            req.isStore    <= 1'b1;
            count          <= STORE_TC;
            state          <= STORE_WAIT;
          end else if (loadValid) begin
            req.index   <= address[31:2];
            req.isStore <= 1'b0;
            count       <= LOAD_TC;
            state       <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            loadData      <= fault ? 32'd0 : rd_data;
            loadDataValid <= 1'b1;
            accessFault   <= fault;
            state         <= COOLDOWN;
          end
        end
        STORE_WAIT: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            storeComplete <= 1'b1;
            accessFault   <= fault;
            state         <= COOLDOWN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios followed by random load/store traffic.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LL    = 2;
  localparam int SL    = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] storeData;
  logic [3:0]  byteEnable;
  logic        storeValid;
  logic        loadValid;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic        accessFault;

  dmem_responder #(
    .DEPTH_WORDS   (DEPTH),
    .LOAD_LATENCY  (LL),
    .STORE_LATENCY (SL)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .storeData     (storeData),
    .byteEnable    (byteEnable),
    .storeValid    (storeValid),
    .loadValid     (loadValid),
    .loadData      (loadData),
    .loadDataValid (loadDataValid),
    .storeComplete (storeComplete),
    .accessFault   (accessFault)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    bit          fault;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model[int];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          pool[8] = '{0, 1, 5, 16, 32, 100, 512, 1023};

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset && accessFault && !loadDataValid && !storeComplete) begin
      checks++; errors++;
      $display("FAIL lone_fault: accessFault=1 without a response at cycle %0d", cyc);
    end
    if (reset && (loadDataValid || storeComplete)) begin
      if (loadDataValid && storeComplete) begin
        checks++; errors++;
        $display("FAIL dual_pulse: both pulses high at cycle %0d", cyc);
      end
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: ldv=%0b sc=%0b at cycle %0d, none expected",
                 loadDataValid, storeComplete, cyc);
      end else begin
        e = q.pop_front();
        checks++;
        if (loadDataValid != e.is_load) begin
          errors++;
          $display("FAIL kind: got load=%0b want load=%0b", loadDataValid, e.is_load);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL latency: response at cycle %0d want %0d", cyc, e.cyc);
        end
        checks++;
        if (accessFault != e.fault) begin
          errors++;
          $display("FAIL fault: got %0b want %0b", accessFault, e.fault);
        end
        if (e.is_load) begin
          checks++;
          if (loadData !== e.data) begin
            errors++;
            $display("FAIL load_data: got %08h want %08h", loadData, e.data);
          end
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (loadData !== 32'd0 || loadDataValid !== 1'b0 || storeComplete !== 1'b0 || accessFault !== 1'b0) begin
      errors++;
      $display("FAIL %s: ld=%08h ldv=%0b sc=%0b af=%0b want all 0", tag, loadData,
               loadDataValid, storeComplete, accessFault);
    end
  endtask

  // Issue one request, hold it until the response pulse, drop it one cycle later.
  task automatic do_req(input bit st, input bit ld, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, input bit scramble);
    exp_t        e;
    int          idx;
    bit          got;
    logic [31:0] w;
    idx = int'(addr[31:2]);
    @(posedge clock); #1;
    storeValid = st; loadValid = ld; address = addr; storeData = data; byteEnable = be;
    e.is_load = !st;
    e.fault   = (addr[31:2] >= 30'(DEPTH));
    e.cyc     = cyc + 1 + (st ? SL : LL);
    e.data    = 32'd0;
    if (st && !e.fault) begin
      w = model.exists(idx) ? model[idx] : 32'd0;
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = data[8*b +: 8];
      model[idx] = w;
    end else if (!st && !e.fault) begin
      e.data = model[idx];
    end
    q.push_back(e);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (loadDataValid || storeComplete) got = 1;
      else if (scramble && i > 0) begin
        address = $urandom; storeData = $urandom; byteEnable = 4'($urandom);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout: no response for addr %08h within 40 cycles", addr);
      q.delete();
    end
    @(posedge clock); #1;
    storeValid = 0; loadValid = 0;
  endtask

  initial begin
    int idx;
    logic [31:0] a;
    reset = 0; address = 0; storeData = 0; byteEnable = 0; storeValid = 0; loadValid = 0;
    repeat (3) @(posedge clock);
    #1 check_idle_outputs("reset_state");
    reset = 1;

    // Reset lands mid LOAD_WAIT: the load must vanish without a pulse.
    @(posedge clock); #1 loadValid = 1; address = 32'h40;
    @(posedge clock); #1 reset = 0; loadValid = 0;
    @(negedge clock); check_idle_outputs("reset_mid_load");
    @(posedge clock); #1 reset = 1;
    repeat (5) @(posedge clock);

    foreach (pool[i]) do_req(1, 0, 32'(pool[i]) << 2, $urandom, 4'hF, 0);

    do_req(1, 0, 32'h40, 32'hDEADBEEF, 4'hF, 0);
    do_req(0, 1, 32'h40, 32'h0, 4'h0, 0);
    do_req(1, 0, 32'h40, 32'h000000AA, 4'b0001, 0);
    do_req(0, 1, 32'h40, 32'h0, 4'h0, 0);
    checks++;
    if (model[16] !== 32'hDEADBEAA) begin
      errors++;
      $display("FAIL merge_model: got %08h want DEADBEAA", model[16]);
    end
    do_req(1, 1, 32'h80, 32'h12345678, 4'hF, 0);
    do_req(0, 1, 32'h80, 32'h0, 4'h0, 0);
    do_req(1, 0, 32'h80, 32'hCAFEF00D, 4'h0, 0);
    do_req(0, 1, 32'h82, 32'h0, 4'h0, 0);
    do_req(0, 1, 32'h00001000, 32'h0, 4'h0, 0);
    do_req(1, 0, 32'h00001000, 32'hFFFFFFFF, 4'hF, 0);
    do_req(0, 1, 32'h00000000, 32'h0, 4'h0, 0);
    do_req(0, 1, 32'hFFFFFFFC, 32'h0, 4'h0, 0);
    do_req(0, 1, 32'h00000FFC, 32'h0, 4'h0, 1);
    repeat (4) @(posedge clock);

    for (int n = 0; n < 80; n++) begin
      idx = ($urandom_range(0, 9) == 0) ? 1024 + int'($urandom_range(0, 3000)) : pool[$urandom_range(0, 7)];
      a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clock);
      case ($urandom_range(0, 2))
        0: do_req(1, 0, a, $urandom, 4'($urandom), $urandom_range(0, 1) == 1);
        1: do_req(0, 1, a, $urandom, 4'($urandom), $urandom_range(0, 1) == 1);
        default: do_req(1, 1, a, $urandom, 4'($urandom), $urandom_range(0, 1) == 1);
      endcase
    end

    repeat (6) @(posedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses still outstanding, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
